div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
Sequencer for the iterative 32-bit integer divider used by the EX stage for div.w, mod.w, div.wu and mod.wu. It latches operands when EX presents a divide and runs one restoring radix-2 iteration per cycle. It drives the EX ready_go stall and holds the result until EX hands the instruction on to MEM. It sits beside the ALU in EX and is cancelled by the EX flush.

Parameters:
DATA_WD, 32, operand/result width; iteration count equals DATA_WD.

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
div_req  in  1  EX holds a valid divide/mod instruction (es_valid & div op)
div_op  in  2  bit0: 1=signed, 0=unsigned; bit1: 1=remainder, 0=quotient
div_src1  in  DATA_WD  dividend
div_src2  in  DATA_WD  divisor
div_cancel  in  1  EX flush; abort any operation
div_res_ack  in  1  EX instruction leaves EX this cycle (es_to_ms_valid & ms_allowin)
div_stall  out  1  EX must hold; feeds es_ready_go = !div_stall
div_res_valid  out  1  div_result is final
div_result  out  DATA_WD  quotient or remainder, selected by latched div_op[1]
div_busy  out  1  state != IDLE (for hazard unit visibility)

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, count=0, all datapath registers=0; div_stall=0, div_res_valid=0, div_result=0, div_busy=0.
- States: IDLE, CALC, DONE. Two-bit state encoding.
- IDLE: if div_req & !div_cancel, latch |src1|, |src2| (absolute values only when div_op[0]=1), both sign bits, div_op, and a divisor-zero flag. Clear the partial remainder, set count=0, go to CALC. Otherwise stay in IDLE.
- CALC, one iteration per cycle: shift {rem,quo} left by 1, trial = rem - divisor (DATA_WD+1 bits). If trial is non-negative, rem=trial and quo LSB=1; otherwise quo LSB=0. count increments. After the iteration with count==DATA_WD-1, go to DONE.
- DONE: div_res_valid=1. Results are sign-fixed and registered on the CALC-to-DONE edge:
  - quotient is negated when signed and sign1^sign2;
  - remainder is negated when signed and sign1;
  - divisor zero overrides: quotient=all ones, remainder=div_src1 as latched.
  Stay in DONE until div_res_ack, then go to IDLE.
- div_stall = div_req & (state != DONE), combinational. Latency: req in cycle 0 (IDLE), CALC in cycles 1..32, DONE in cycle 33 with stall low. Minimum EX occupancy is 34 cycles.
- div_result is held stable throughout DONE. It keeps its value in IDLE and is not reset between operations.
- div_cancel has priority in every state: next state is IDLE and count=0. No res_valid is produced. If div_cancel and div_req arrive together in IDLE, no operation starts.
- Overflow 0x80000000 / 0xFFFFFFFF signed: quotient=0x80000000, remainder=0 (wraparound, no trap).
- After an ack, state returns to IDLE first. A back-to-back divide in EX therefore starts in the following cycle, so the same instruction is never launched twice.
- If div_req drops while in CALC or DONE without a cancel (must not happen in the pipeline): abort to IDLE and flag an assertion in simulation.
- Operands are sampled only in IDLE. Later changes on div_src1/div_src2 are ignored.

Decomposition:
- Shared myCPU.vh gets the DIV_OP bit positions (DIV_OP_SIGNED, DIV_OP_REM) and the state encodings DIV_IDLE, DIV_CALC and DIV_DONE.
- One natural sub-module is div_step, a purely combinational single restoring iteration: {rem_in, quo_in, divisor} -> {rem_out, quo_out}.
- Sign fixing and zero-override stay in div_ctrl.

Test Plan:
- Unsigned quotient: 100 / 7 (op=00), ack when valid -> stall high for cycles 0..32, res_valid in cycle 33, result 14.
- Signed remainder: -7 / 2 (0xFFFFFFF9 / 2, op=11) -> result 0xFFFFFFFF (-1). With op=01 the result is 0xFFFFFFFD (-3).
- Divide by zero: 0x12345678 / 0, op=00 gives 0xFFFFFFFF; op=10 gives 0x12345678. Signed overflow 0x80000000 / 0xFFFFFFFF, op=01 -> 0x80000000.
- Flush mid-operation: cancel at cycle 10 of CALC -> next cycle IDLE, busy=0, no res_valid. A new req of 9/3 then yields 3 after 34 cycles.
- Hold in DONE: withhold ack for 5 cycles -> res_valid and result stable, stall=0. Ack, then an immediate second req of 0xFFFFFFFF / 0x10 (op=00) -> IDLE for one cycle, then result 0x0FFFFFFF.
- Asynchronous reset: deassert resetn at mid-CALC, between clock edges -> all outputs 0 immediately. After release, the first req completes correctly.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared constants for the EX-stage iterative divider sequencer.
// Contents: div_op bit positions and the two-bit sequencer state encodings.
// Imported by div_ctrl; no ports.
package div_ctrl_pkg;

    // div_op bit positions
    localparam int DIV_OP_SIGNED = 0;   // 1 = signed (div.w / mod.w)
    localparam int DIV_OP_REM    = 1;   // 1 = remainder (mod.*), 0 = quotient

    // Sequencer state encodings
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_CALC = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division iteration, purely combinational.
// Ports: rem_in/quo_in/divisor in; rem_out/quo_out are the shifted and updated pair.
// The caller guarantees rem_in < divisor, so the trial fits in DATA_WD+1 bits.
module div_step #(
    parameter int DATA_WD = 32
) (
    input  logic [DATA_WD-1:0] rem_in,
    input  logic [DATA_WD-1:0] quo_in,
    input  logic [DATA_WD-1:0] divisor,
    output logic [DATA_WD-1:0] rem_out,
    output logic [DATA_WD-1:0] quo_out
);

    logic [DATA_WD:0] shifted;
    logic [DATA_WD:0] trial;
    logic             trial_neg;

    // {rem,quo} << 1: the dividend MSB moves into the remainder LSB.
    assign shifted = {rem_in, quo_in[DATA_WD-1]};
    assign trial   = shifted - {1'b0, divisor};
    // A non-negative trial is always < divisor < 2^DATA_WD, so bit DATA_WD
    // is set only when the subtraction wrapped.
    assign trial_neg = trial[DATA_WD];

    assign rem_out = trial_neg ? shifted[DATA_WD-1:0] : trial[DATA_WD-1:0];
    assign quo_out = {quo_in[DATA_WD-2:0], ~trial_neg};

endmodule

// File: rtl/div_ctrl.sv
// Sequencer for the EX-stage 32-bit iterative divider (div.w/mod.w/div.wu/mod.wu).
// Ports: clk/resetn; div_req/div_op/div_src1/div_src2 launch; div_cancel flushes;
// div_res_ack retires; div_stall/div_res_valid/div_result/div_busy report status.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_WD = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               div_req,
    input  logic [1:0]         div_op,
    input  logic [DATA_WD-1:0] div_src1,
    input  logic [DATA_WD-1:0] div_src2,
    input  logic               div_cancel,
    input  logic               div_res_ack,
    output logic               div_stall,
    output logic               div_res_valid,
    output logic [DATA_WD-1:0] div_result,
    output logic               div_busy
);

    localparam int CNT_WD = $clog2(DATA_WD);
    localparam logic [CNT_WD-1:0] LAST_CNT = CNT_WD'(DATA_WD - 1);

    logic [1:0]         state;
    logic [CNT_WD-1:0]  count;
    logic [DATA_WD-1:0] rem;
    logic [DATA_WD-1:0] quo;
    logic [DATA_WD-1:0] dvsr;
    logic [1:0]         op_q;
    logic               sign1;
    logic               sign2;
    logic               dvsr_zero;
    logic [DATA_WD-1:0] res_q;

    logic [DATA_WD-1:0] step_rem;
    logic [DATA_WD-1:0] step_quo;
    logic [DATA_WD-1:0] abs1;
    logic [DATA_WD-1:0] abs2;
    logic [DATA_WD-1:0] quo_fix;
    logic [DATA_WD-1:0] rem_fix;
    logic [DATA_WD-1:0] final_res;

    // Magnitudes are taken only for signed ops.
    assign abs1 = (div_op[DIV_OP_SIGNED] & div_src1[DATA_WD-1]) ? -div_src1 : div_src1;
    assign abs2 = (div_op[DIV_OP_SIGNED] & div_src2[DATA_WD-1]) ? -div_src2 : div_src2;

    div_step #(.DATA_WD(DATA_WD)) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (dvsr),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Sign fix applied to the outputs of the final iteration.
    // With a zero divisor every trial succeeds, so the remainder ends as |src1|
    // and the sign fix turns it back into src1 exactly; only the quotient
    // needs an explicit override.
    assign quo_fix   = (op_q[DIV_OP_SIGNED] & (sign1 ^ sign2)) ? -step_quo : step_quo;
    assign rem_fix   = (op_q[DIV_OP_SIGNED] & sign1) ? -step_rem : step_rem;
    assign final_res = op_q[DIV_OP_REM] ? rem_fix
                     : (dvsr_zero ? {DATA_WD{1'b1}} : quo_fix);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= DIV_IDLE;
            count     <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            op_q      <= '0;
            sign1     <= 1'b0;
            sign2     <= 1'b0;
            dvsr_zero <= 1'b0;
            res_q     <= '0;
        end else if (div_cancel) begin
            state <= DIV_IDLE;
            count <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (div_req) begin
                        state     <= DIV_CALC;
                        count     <= '0;
                        rem       <= '0;
                        quo       <= abs1;
                        dvsr      <= abs2;
                        op_q      <= div_op;
                        sign1     <= div_src1[DATA_WD-1];
                        sign2     <= div_src2[DATA_WD-1];
                        dvsr_zero <= (div_src2 == '0);
                    end
                end
                DIV_CALC: begin
                    if (!div_req) begin
                        // EX lost the instruction without a flush: drop the work.
                        state <= DIV_IDLE;
                        count <= '0;
                    end else begin
                        rem   <= step_rem;
                        quo   <= step_quo;
                        count <= count + CNT_WD'(1);
                        if (count == LAST_CNT) begin
                            state <= DIV_DONE;
                            res_q <= final_res;
                        end
                    end
                end
                DIV_DONE: begin
                    // Always pass through IDLE so one instruction launches once.
                    if (!div_req || div_res_ack) begin
                        state <= DIV_IDLE;
                        count <= '0;
                    end
                end
                default: begin
                    state <= DIV_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    assign div_stall     = div_req & (state != DIV_DONE);
    assign div_res_valid = (state == DIV_DONE);
    assign div_result    = res_q;
    assign div_busy      = (state != DIV_IDLE);

    // EX must keep the request up until it is retired or flushed.
    req_held_a: assert property (@(posedge clk) disable iff (!resetn)
        (state != DIV_IDLE) |-> (div_req || div_cancel))
        else $error("div_ctrl: div_req dropped while busy");

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed cases, random cases, cancel, hold and reset.
module tb_div_ctrl;

    logic        clk;
    logic        resetn;
    logic        div_req;
    logic [1:0]  div_op;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_cancel;
    logic        div_res_ack;
    logic        div_stall;
    logic        div_res_valid;
    logic [31:0] div_result;
    logic        div_busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    div_ctrl #(.DATA_WD(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .div_req       (div_req),
        .div_op        (div_op),
        .div_src1      (div_src1),
        .div_src2      (div_src2),
        .div_cancel    (div_cancel),
        .div_res_ack   (div_res_ack),
        .div_stall     (div_stall),
        .div_res_valid (div_res_valid),
        .div_result    (div_result),
        .div_busy      (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return op[1] ? 32'h0 : 32'h8000_0000;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Launch one divide in the current (IDLE) cycle, wait for the result,
    // optionally hold it in DONE, then ack. Returns 1 ns after the edge that
    // leaves DONE, with req/ack low.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input int hold,
                          input logic [31:0] exp, input string tag);
        int   cyc;
        logic stall_ok;
        logic hold_ok;
        logic [31:0] held;
        logic [31:0] e;
        exp_q.push_back(exp);
        div_req  = 1'b1;
        div_op   = op;
        div_src1 = a;
        div_src2 = b;
        #1;
        chk({tag, "_stall_c0"}, {31'b0, div_stall}, 32'd1);
        cyc      = 0;
        stall_ok = 1'b1;
        while (cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                // Operands must be ignored once the operation is running.
                div_src1 = $urandom;
                div_src2 = $urandom;
            end
            if (div_res_valid) break;
            if (!div_stall || !div_busy) stall_ok = 1'b0;
        end
        if (!div_res_valid) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
            div_req = 1'b0;
            return;
        end
        chk({tag, "_latency"}, cyc, 32'd33);
        chk({tag, "_stall_calc"}, {31'b0, stall_ok}, 32'd1);
        chk({tag, "_stall_done"}, {31'b0, div_stall}, 32'd0);
        e = exp_q.pop_front();
        chk({tag, "_result"}, div_result, e);
        held    = div_result;
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!div_res_valid || div_stall || div_result !== held) hold_ok = 1'b0;
        end
        if (hold > 0) chk({tag, "_hold"}, {31'b0, hold_ok}, 32'd1);
        div_res_ack = 1'b1;
        @(posedge clk); #1;
        div_res_ack = 1'b0;
        div_req     = 1'b0;
        chk({tag, "_idle_after_ack"}, {30'b0, div_busy, div_res_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;
        logic        seen_valid;

        resetn      = 1'b0;
        div_req     = 1'b0;
        div_op      = 2'b00;
        div_src1    = 32'h0;
        div_src2    = 32'h0;
        div_cancel  = 1'b0;
        div_res_ack = 1'b0;
        #12;
        chk("reset_outputs", {div_stall, div_res_valid, div_busy, 29'b0}, 32'd0);
        chk("reset_result", div_result, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_div(32'd100,        32'd7,        2'b00, 0, 32'd14,         "udiv");
        do_div(32'hFFFF_FFF9,  32'd2,        2'b11, 0, 32'hFFFF_FFFF,  "srem");
        do_div(32'hFFFF_FFF9,  32'd2,        2'b01, 5, 32'hFFFF_FFFD,  "sdiv_hold");
        do_div(32'hFFFF_FFFF,  32'h10,       2'b00, 0, 32'h0FFF_FFFF,  "b2b");
        do_div(32'h1234_5678,  32'd0,        2'b00, 0, 32'hFFFF_FFFF,  "dz_quo");
        do_div(32'h1234_5678,  32'd0,        2'b10, 0, 32'h1234_5678,  "dz_rem");
        do_div(32'hFFFF_FFF9,  32'd0,        2'b01, 0, 32'hFFFF_FFFF,  "dz_squo");
        do_div(32'hFFFF_FFF9,  32'd0,        2'b11, 0, 32'hFFFF_FFF9,  "dz_srem");
        do_div(32'h8000_0000,  32'hFFFF_FFFF, 2'b01, 0, 32'h8000_0000, "ovf_quo");
        do_div(32'h8000_0000,  32'hFFFF_FFFF, 2'b11, 0, 32'h0,         "ovf_rem");

        // Random cases against the behavioural model
        for (int i = 0; i < 8; i++) begin
            ra  = $urandom;
            rb  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            rop = 2'($urandom_range(0, 3));
            if (i % 4 == 3) rb = -rb;
            do_div(ra, rb, rop, i % 3, model(ra, rb, rop), "rand");
        end

        // Flush in the 10th CALC cycle: no result may appear
        div_req  = 1'b1;
        div_op   = 2'b00;
        div_src1 = 32'd100;
        div_src2 = 32'd7;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("cancel_busy_before", {31'b0, div_busy}, 32'd1);
        div_cancel = 1'b1;
        @(posedge clk); #1;
        div_cancel = 1'b0;
        div_req    = 1'b0;
        chk("cancel_idle", {30'b0, div_busy, div_res_valid}, 32'd0);
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_res_valid || div_busy) seen_valid = 1'b1;
        end
        chk("cancel_no_valid", {31'b0, seen_valid}, 32'd0);
        do_div(32'd9, 32'd3, 2'b00, 0, 32'd3, "after_cancel");

        // Cancel arriving together with a request in IDLE starts nothing
        div_req    = 1'b1;
        div_cancel = 1'b1;
        div_src1   = 32'd50;
        div_src2   = 32'd5;
        @(posedge clk); #1;
        div_req    = 1'b0;
        div_cancel = 1'b0;
        chk("cancel_with_req", {31'b0, div_busy}, 32'd0);

        // Asynchronous reset between clock edges, mid-CALC
        div_req  = 1'b1;
        div_op   = 2'b00;
        div_src1 = 32'd1000;
        div_src2 = 32'd10;
        repeat (15) begin
            @(posedge clk); #1;
        end
        #2;
        resetn  = 1'b0;
        div_req = 1'b0;
        #1;
        chk("async_reset_flags", {29'b0, div_stall, div_res_valid, div_busy}, 32'd0);
        chk("async_reset_result", div_result, 32'd0);
        @(posedge clk); #3;
        resetn = 1'b1;
        @(posedge clk); #1;
        do_div(32'd100, 32'd7, 2'b00, 0, 32'd14, "after_reset");

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
